fft_col_collector: RTL and testbench
====================================

// Module: fft_col_collector
// PURPOSE
//  Downstream neighbour of the column-2 butterfly stage. Each step, the NUM_MAC time-multiplexed MAC lanes each produce 2 complex results.
//  This block gathers the results of all STEPS steps into one 32-word frame, in the same scatter order the MAC demux uses.
//  Two frame banks work as a ping-pong pair, so capture of frame N+1 overlaps hand-off of frame N.
//  Completed frames go to column 3 or the result sink over a valid/ready handshake.
// PARAMETERS
//  DW       64  complex word width; [DW-1:DW/2] = real fp32, [DW/2-1:0] = imag fp32
//  NUM_MAC  4   number of MAC lanes feeding this block
//  STEPS    4   sel steps per frame; FRAME = NUM_MAC*2*STEPS = 32 words
//  CW       16  width of frame counter
// PORTS
//  clk         in   1                 clock, all logic on posedge
//  reset       in   1                 synchronous, active-high
//  in_valid    in   1                 lane_data/in_sel valid this cycle
//  in_ready    out  1                 block can accept a step
//  in_sel      in   log2(STEPS)       step index (= MAC mux select)
//  lane_data   in   NUM_MAC*2*DW      lane m: out1 at [(2m)*DW+:DW], out2 at [(2m+1)*DW+:DW]
//  frame_valid out  1                 a complete frame is presented
//  frame_ready in   1                 consumer accepts the frame
//  frame_data  out  FRAME*DW          word k at [k*DW+:DW]
//  dup_err     out  1                 1-cycle pulse: step index repeated within the current frame
//  frame_cnt   out  CW                frames handed off (valid&ready), wraps modulo 2^CW
// BEHAVIOUR
//  - Reset values: in_ready=1, frame_valid=0, dup_err=0, frame_cnt=0, wr_bank=rd_bank=0, full=2'b00, step_mask=0.
//    Bank storage is not reset. frame_data is don't-care while frame_valid=0.
//  - Accept: a step is accepted when in_valid & in_ready.
//    For lane m at step s: out1 is written to word m*8+s, out2 to word m*8+4+s (general form: m*2*STEPS + s, m*2*STEPS + STEPS + s).
//    step_mask[s] is set.
//  - Steps may arrive in any order.
//    A repeated s overwrites the stored data, pulses dup_err on the next cycle, and leaves step_mask unchanged.
//  - Completion: if an accepted step makes step_mask all-ones:
//    full[wr_bank] <= 1, wr_bank toggles, and step_mask clears, all in the same edge.
//    frame_valid rises 1 cycle after the completing accept.
//  - in_ready = ~full[wr_bank], combinational from registers only; it has no path from in_valid.
//  - frame_valid = full[rd_bank]. frame_data = bank[rd_bank] and is held stable while frame_valid & ~frame_ready.
//  - Hand-off (frame_valid & frame_ready): full[rd_bank] <= 0, rd_bank toggles, frame_cnt++.
//  - Both banks full: in_ready=0 and in_valid is ignored; the upstream stage must stall.
//  - Same cycle completion on wr_bank and hand-off on rd_bank (different banks): both take effect and no frame is lost.
//    With 2 banks, throughput is one frame per STEPS cycles when frame_ready=1.
//  - Reset mid-frame discards the partial frame and any full banks. The first post-reset frame is clean.
// STRUCTURE
//  - Shared package fft_pkg: DW, NUM_MAC, STEPS, FRAME constants; complex-word typedef (re/im fp32); function frame_idx(m,half,s).
//  - Sub-module fft_frame_bank (one per bank, 2 instances).
//    It holds FRAME words and has a step-write port (we, sel, lane_data) that scatters via frame_idx.
//    Its read side is a flat output.
//  - Top: step_mask/dup logic, wr/rd bank pointers, full[1:0], handshake, frame_cnt, output mux.
// TESTING
//  - Reset, then 4 steps s=0..3 back-to-back. lane m out1=64'h{m,s,1}, out2={m,s,2}.
//    -> frame_valid high on the cycle after step 3. Word 13 (m=1,out2,s=1) = {1,1,2}. frame_cnt=1 after ready.
//  - Out-of-order sel 3,1,0,2 -> identical frame to in-order. dup_err stays 0.
//  - sel sequence 0,0,1,2,3 with the second 0 carrying new data -> dup_err pulses once, and words 0,4,8,... hold the second value.
//  - frame_ready=0 for 3 frames -> in_ready drops after the 8th accepted step.
//    Raise ready -> frames emerge in order 1,2 and then 3. No data corruption.
//  - frame_ready=1 continuous, in_valid every cycle -> one frame per 4 cycles and in_ready never drops.
//  - Reset asserted after 2 steps -> frame_valid=0, in_ready=1.
//    The next 4 steps form a frame containing no pre-reset data, and frame_cnt restarts at 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, complex-word type and the lane/step-to-frame scatter mapping used by
// the column-2 MAC demux and its downstream collector.
package fft_pkg;

  localparam int unsigned DW      = 64;
  localparam int unsigned NUM_MAC = 4;
  localparam int unsigned STEPS   = 4;
  localparam int unsigned FRAME   = NUM_MAC * 2 * STEPS;
  localparam int unsigned CW      = 16;
  localparam int unsigned SEL_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned IDX_W   = (FRAME > 1) ? $clog2(FRAME) : 1;

  // Complex word: real part in the upper half, imaginary in the lower half.
  typedef struct packed {
    logic [DW/2-1:0] re;
    logic [DW/2-1:0] im;
  } cplx_t;

  // Frame slot of output `half` (0 = out1, 1 = out2) of lane m at step s.
  function automatic logic [IDX_W-1:0] frame_idx(input int unsigned       m,
                                                 input logic              half,
                                                 input logic [SEL_W-1:0]  s);
    int unsigned idx;
    idx = m * 2 * STEPS + 32'(s);
    if (half) begin
      idx = idx + STEPS;
    end
    return IDX_W'(idx);
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of storage. A step write scatters every lane's two results into their frame
// slots; the whole frame is presented flat on the read side.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     we,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_MAC*2*DW-1:0]  lane_data,
  output logic [FRAME*DW-1:0]      frame_words
);

  // Payload storage only; validity lives in the collector, so no reset here.
  cplx_t mem_q [FRAME];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int m = 0; m < int'(NUM_MAC); m++) begin
        for (int h = 0; h < 2; h++) begin
          mem_q[frame_idx(m, 1'(h), sel)] <= cplx_t'(lane_data[(2*m+h)*DW +: DW]);
        end
      end
    end
  end

  for (genvar k = 0; k < int'(FRAME); k++) begin : g_flat
    assign frame_words[k*DW +: DW] = mem_q[k];
  end

endmodule

// File: rtl/fft_col_collector.sv
// Gathers STEPS lane steps into a frame over a ping-pong pair of banks and hands completed
// frames downstream over valid/ready.
module fft_col_collector
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [NUM_MAC*2*DW-1:0]  lane_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [FRAME*DW-1:0]      frame_data,
  output logic                     dup_err,
  output logic [CW-1:0]            frame_cnt
);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [STEPS-1:0] step_mask_q, step_mask_d;
  logic             dup_err_q;
  logic [CW-1:0]    frame_cnt_q, frame_cnt_d;

  logic             accept;
  logic             handoff;
  logic [STEPS-1:0] sel_onehot;
  logic [STEPS-1:0] mask_set;
  logic             step_dup;
  logic             step_complete;
  logic [1:0]       bank_we;
  logic [FRAME*DW-1:0] bank_data [2];

  // in_ready depends on registers only, never on in_valid.
  assign in_ready    = ~full_q[wr_bank_q];
  assign frame_valid = full_q[rd_bank_q];
  assign frame_data  = bank_data[rd_bank_q];
  assign dup_err     = dup_err_q;
  assign frame_cnt   = frame_cnt_q;

  assign accept  = in_valid & in_ready;
  assign handoff = frame_valid & frame_ready;

  always_comb begin
    sel_onehot         = '0;
    sel_onehot[in_sel] = 1'b1;
    mask_set           = step_mask_q | sel_onehot;
    step_dup           = accept & |(step_mask_q & sel_onehot);
    step_complete      = accept & (&mask_set);

    bank_we            = '0;
    bank_we[wr_bank_q] = accept;
  end

  // Completion targets wr_bank (empty) and hand-off targets rd_bank (full), so the two
  // never touch the same bank in one cycle.
  always_comb begin
    full_d = full_q;
    if (handoff) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (step_complete) begin
      full_d[wr_bank_q] = 1'b1;
    end

    step_mask_d = step_mask_q;
    if (step_complete) begin
      step_mask_d = '0;
    end else if (accept) begin
      step_mask_d = mask_set;
    end

    wr_bank_d   = wr_bank_q ^ step_complete;
    rd_bank_d   = rd_bank_q ^ handoff;
    frame_cnt_d = frame_cnt_q + CW'(handoff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      step_mask_q <= '0;
      dup_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      step_mask_q <= step_mask_d;
      dup_err_q   <= step_dup;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank u_bank (
      .clk         (clk),
      .we          (bank_we[b]),
      .sel         (in_sel),
      .lane_data   (lane_data),
      .frame_words (bank_data[b])
    );
  end

  // A presented frame must stay put while the consumer stalls.
  frame_hold_a : assert property (@(posedge clk) disable iff (reset)
    (frame_valid && !frame_ready) |=> $stable(frame_data));

endmodule

// File: tb/tb_fft_col_collector.sv
// Directed bench for fft_col_collector: framing, ordering, duplicates, backpressure,
// streaming throughput and mid-frame reset.
module tb_fft_col_collector;

  localparam int DW      = 64;
  localparam int NUM_MAC = 4;
  localparam int STEPS   = 4;
  localparam int FRAME   = 32;
  localparam int CW      = 16;

  logic                    clk;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_sel;
  logic [NUM_MAC*2*DW-1:0] lane_data;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [FRAME*DW-1:0]     frame_data;
  logic                    dup_err;
  logic [CW-1:0]           frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fft_col_collector dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .lane_data   (lane_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .dup_err     (dup_err),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Word value {tag, m, s, h} with m, s, h as single hex digits.
  function automatic logic [63:0] val(input int m, input int s, input int h, input int tag);
    logic [15:0] t;
    logic [3:0]  mm, ss, hh;
    t  = 16'(tag);
    mm = 4'(m);
    ss = 4'(s);
    hh = 4'(h);
    return {t, 36'h0, mm, ss, hh};
  endfunction

  function automatic logic [NUM_MAC*2*DW-1:0] build(input int s, input int tag);
    logic [NUM_MAC*2*DW-1:0] d;
    for (int m = 0; m < NUM_MAC; m++) begin
      d[(2*m)*DW +: DW]   = val(m, s, 1, tag);
      d[(2*m+1)*DW +: DW] = val(m, s, 2, tag);
    end
    return d;
  endfunction

  // Expected frame layout: 8 words per lane, out1 slots 0..3 then out2 slots 4..7.
  function automatic logic [63:0] exp_word(input int k, input int tag);
    return val(k / 8, k % 4, (k % 8) / 4 + 1, tag);
  endfunction

  task automatic check_frame(input string name, input int tag);
    for (int k = 0; k < FRAME; k++) begin
      check($sformatf("%s_w%0d", name, k), frame_data[k*DW +: DW], exp_word(k, tag));
    end
  endtask

  task automatic step(input int s, input int tag);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("step_wait_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_sel    = 2'(s);
    lane_data = build(s, tag);
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic take_frame();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int dup_pulses;
    int nfr;

    reset = 1'b1; in_valid = 1'b0; in_sel = '0; lane_data = '0; frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_dup_err", dup_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    // In-order frame
    for (int s = 0; s < 3; s++) step(s, 1);
    check("t1_valid_before_last", frame_valid, 0);
    step(3, 1);
    check("t1_valid_after_last", frame_valid, 1);
    check("t1_word13_low", {52'h0, frame_data[13*DW +: 12]}, 64'h112);
    check_frame("t1", 1);
    take_frame();
    check("t1_cnt", frame_cnt, 1);
    check("t1_valid_gone", frame_valid, 0);

    // Out-of-order frame
    step(3, 2); check("t2_dup_a", dup_err, 0);
    step(1, 2); check("t2_dup_b", dup_err, 0);
    step(0, 2); check("t2_dup_c", dup_err, 0);
    check("t2_valid_early", frame_valid, 0);
    step(2, 2); check("t2_dup_d", dup_err, 0);
    check("t2_valid", frame_valid, 1);
    check_frame("t2", 2);
    take_frame();
    check("t2_cnt", frame_cnt, 2);

    // Duplicate step overwrites data
    dup_pulses = 0;
    step(0, 3); check("t3_dup_first", dup_err, 0); dup_pulses += int'(dup_err);
    step(0, 4); check("t3_dup_repeat", dup_err, 1); dup_pulses += int'(dup_err);
    step(1, 4); check("t3_dup_after", dup_err, 0); dup_pulses += int'(dup_err);
    check("t3_valid_early", frame_valid, 0);
    step(2, 4); dup_pulses += int'(dup_err);
    step(3, 4); dup_pulses += int'(dup_err);
    check("t3_dup_pulses", dup_pulses, 1);
    check("t3_valid", frame_valid, 1);
    check_frame("t3", 4);
    take_frame();
    check("t3_cnt", frame_cnt, 3);

    // Backpressure: two banks fill, then drain in order
    for (int i = 0; i < 7; i++) step(i % 4, 5 + i / 4);
    check("t4_ready_after7", in_ready, 1);
    step(3, 6);
    check("t4_ready_after8", in_ready, 0);
    in_valid = 1'b1; in_sel = 2'd0; lane_data = build(0, 9);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("t4_ready_held", in_ready, 0);
    check_frame("t4_f1", 5);
    take_frame();
    check("t4_cnt1", frame_cnt, 4);
    check("t4_ready_reopen", in_ready, 1);
    check_frame("t4_f2", 6);
    for (int s = 0; s < 4; s++) step(s, 7);
    check("t4_ready_full_again", in_ready, 0);
    check_frame("t4_f2_held", 6);
    take_frame();
    check("t4_cnt2", frame_cnt, 5);
    check_frame("t4_f3", 7);
    take_frame();
    check("t4_cnt3", frame_cnt, 6);
    check("t4_drained", frame_valid, 0);
    check("t4_ready_end", in_ready, 1);

    // Streaming: one frame per STEPS cycles, in_ready never drops
    frame_ready = 1'b1;
    nfr = 0;
    for (int i = 0; i < 12; i++) begin
      check("t5_in_ready", in_ready, 1);
      in_valid = 1'b1; in_sel = 2'(i % 4); lane_data = build(i % 4, 10 + i / 4);
      @(negedge clk);
      if (frame_valid) begin
        check("t5_spacing", 64'(i % 4), 3);
        check_frame($sformatf("t5_f%0d", nfr), 10 + nfr);
        nfr++;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    frame_ready = 1'b0;
    check("t5_frames", 64'(nfr), 3);
    check("t5_cnt", frame_cnt, 9);
    check("t5_idle", frame_valid, 0);

    // Reset discards a full bank and a partial frame
    for (int s = 0; s < 4; s++) step(s, 13);
    step(0, 15);
    step(1, 15);
    check("t6_pre_valid", frame_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_rst_valid", frame_valid, 0);
    check("t6_rst_ready", in_ready, 1);
    check("t6_rst_cnt", frame_cnt, 0);
    step(2, 14);
    step(3, 14);
    check("t6_no_stale_mask", frame_valid, 0);
    step(0, 14);
    step(1, 14);
    check("t6_valid", frame_valid, 1);
    check_frame("t6", 14);
    check("t6_cnt_before", frame_cnt, 0);
    take_frame();
    check("t6_cnt_after", frame_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
